r4u2_one_ctrl: RTL and testbench

- Address sequencer for the 64-entry stage-one RAM of pipeline FFT radix-4 unit 2.
- Performs in-place read-before-write reordering: writes frame k+1 into the RAM while reading frame k in radix-4 DIF butterfly order (x[n], x[n+16], x[n+32], x[n+48], n = 0..15).
- Sits between the stage input stream and the RAM wrapper; its output stream feeds the stage-one butterfly.

---
 rtl/r4u2_one_ctrl_pkg.sv | 22 ++
 rtl/r4u2_one_ctrl_if.sv | 36 +++
 rtl/r4u2_digit_rot.sv | 21 ++
 rtl/r4u2_one_ctrl.sv | 95 +++++++++
 tb/tb_r4u2_one_ctrl.sv | 223 ++++++++++++++++++++++
 5 files changed

// File: rtl/r4u2_one_ctrl_pkg.sv
// Shared definitions for the radix-4 unit-2 stage-one address sequencer.
// Sample width, frame depth, controller state encoding and the mode-step helper.
package r4u2_one_ctrl_pkg;

  localparam int MAN_WIDTH          = 16;
  localparam int EXP_WIDTH          = 6;
  localparam int SAMPLE_W           = MAN_WIDTH + MAN_WIDTH + EXP_WIDTH;
  localparam int FFT_R4U2_ONE_DEPTH = 64;
  localparam int ONE_ADDR_W         = 6;

  typedef enum logic [1:0] {
    ST_FILL   = 2'd0,
    ST_STREAM = 2'd1,
    ST_DRAIN  = 2'd2
  } state_t;

  // Digit rotation has period 3, so the mode cycles 0 -> 1 -> 2 -> 0.
  function automatic logic [1:0] next_mode(input logic [1:0] m);
    return (m == 2'd2) ? 2'd0 : m + 2'd1;
  endfunction

endpackage

// File: rtl/r4u2_one_ctrl_if.sv
// Stream-in, RAM-port and stream-out bundle of the stage-one controller.
// The master side is the controller; the slave side is its parent/RAM/stream environment.
interface r4u2_one_ctrl_if
  import r4u2_one_ctrl_pkg::*;
#(
  parameter int DATA_W = SAMPLE_W,
  parameter int ADDR_W = ONE_ADDR_W
);

  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              flush;
  logic [ADDR_W-1:0] ram_rd_addr;
  logic [DATA_W-1:0] ram_rd_data;
  logic              ram_wr_en;
  logic [ADDR_W-1:0] ram_wr_addr;
  logic [DATA_W-1:0] ram_wr_data;
  logic              out_valid;
  logic              out_sop;
  logic              out_eop;
  logic [DATA_W-1:0] out_data;

  modport master (
    input  in_valid, in_data, flush, ram_rd_data,
    output in_ready, ram_rd_addr, ram_wr_en, ram_wr_addr, ram_wr_data,
           out_valid, out_sop, out_eop, out_data
  );

  modport slave (
    output in_valid, in_data, flush, ram_rd_data,
    input  in_ready, ram_rd_addr, ram_wr_en, ram_wr_addr, ram_wr_data,
           out_valid, out_sop, out_eop, out_data
  );

endinterface

// File: rtl/r4u2_digit_rot.sv
// Right rotation of a 3-digit base-4 address by 0, 1 or 2 digit positions.
// Shared by the radix-4 stage controllers; rot_i = 3 is treated as identity.
module r4u2_digit_rot #(
  parameter int ADDR_W = 6
) (
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [1:0]        rot_i,
  output logic [ADDR_W-1:0] addr_o
);

  // Digits (j2 j1 j0): one step gives (j0 j2 j1), two steps give (j1 j0 j2).
  always_comb begin
    addr_o = addr_i;
    case (rot_i)
      2'd1:    addr_o = {addr_i[1:0], addr_i[5:2]};
      2'd2:    addr_o = {addr_i[3:0], addr_i[5:4]};
      default: addr_o = addr_i;
    endcase
  end

endmodule

// File: rtl/r4u2_one_ctrl.sv
// In-place read-before-write address sequencer for the 64-entry stage-one RAM.
// Writes frame k+1 while reading frame k in radix-4 DIF butterfly order.
module r4u2_one_ctrl
  import r4u2_one_ctrl_pkg::*;
#(
  parameter int DATA_W = SAMPLE_W,
  parameter int ADDR_W = ONE_ADDR_W
) (
  input  logic             clk_sys,
  input  logic             rst_sys_n,
  r4u2_one_ctrl_if.master  bus
);

  localparam logic [ADDR_W-1:0] CNT_LAST = ADDR_W'(FFT_R4U2_ONE_DEPTH - 1);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [1:0]        mode_q, mode_d;
  logic              vld_p1_q, vld_p1_d;
  logic              sop_p1_q, sop_p1_d;
  logic              eop_p1_q, eop_p1_d;

  logic              in_ready;
  logic              beat;
  logic              adv;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wr_data_w;

  r4u2_digit_rot #(.ADDR_W(ADDR_W)) u_rot (
    .addr_i (cnt_q),
    .rot_i  (mode_q),
    .addr_o (addr)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    mode_d   = mode_q;
    in_ready = (state_q != ST_DRAIN);
    beat     = bus.in_valid & in_ready;
    // DRAIN walks the frame on its own; otherwise only accepted beats advance.
    adv      = beat | (state_q == ST_DRAIN);
    vld_p1_d = adv & (state_q != ST_FILL);
    sop_p1_d = adv & (cnt_q == '0);
    eop_p1_d = adv & (cnt_q == CNT_LAST);

    if (adv) begin
      cnt_d = cnt_q + ADDR_W'(1);
      if (cnt_q == CNT_LAST) begin
        mode_d = next_mode(mode_q);
        case (state_q)
          ST_FILL:  state_d = ST_STREAM;
          ST_DRAIN: begin
            state_d = ST_FILL;
            mode_d  = 2'd0;
          end
          default:  state_d = state_q;
        endcase
      end
    end else if (bus.flush && (cnt_q == '0) && (state_q == ST_STREAM)) begin
      state_d = ST_DRAIN;
    end
  end

  always_ff @(posedge clk_sys) begin
    if (!rst_sys_n) begin
      state_q  <= ST_FILL;
      cnt_q    <= '0;
      mode_q   <= 2'd0;
      vld_p1_q <= 1'b0;
      sop_p1_q <= 1'b0;
      eop_p1_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      mode_q   <= mode_d;
      vld_p1_q <= vld_p1_d;
      sop_p1_q <= sop_p1_d;
      eop_p1_q <= eop_p1_d;
    end
  end

  // p1 boundary: flags line up with the registered RAM read data.
  assign wr_data_w       = bus.in_data;
  assign bus.in_ready    = in_ready;
  assign bus.ram_rd_addr = addr;
  assign bus.ram_wr_addr = addr;
  assign bus.ram_wr_data = wr_data_w;
  assign bus.ram_wr_en   = ~beat;
  assign bus.out_valid   = vld_p1_q;
  assign bus.out_sop     = sop_p1_q;
  assign bus.out_eop     = eop_p1_q;
  assign bus.out_data    = bus.ram_rd_data;

endmodule

// File: tb/tb_r4u2_one_ctrl.sv
// Scoreboard bench for r4u2_one_ctrl with a read-before-write RAM model and a
// frame-level reference model of the butterfly reordering.
module tb_r4u2_one_ctrl;
  import r4u2_one_ctrl_pkg::*;

  localparam int DW = SAMPLE_W;
  localparam int AW = ONE_ADDR_W;

  typedef struct packed {
    logic [DW-1:0] d;
    logic          sop;
    logic          eop;
  } exp_t;

  logic clk_sys   = 1'b0;
  logic rst_sys_n = 1'b0;
  always #5 clk_sys = ~clk_sys;

  r4u2_one_ctrl_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

  r4u2_one_ctrl #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk_sys   (clk_sys),
    .rst_sys_n (rst_sys_n),
    .bus       (bus)
  );

  logic [DW-1:0] mem [64];
  always @(posedge clk_sys) begin
    bus.ram_rd_data <= mem[bus.ram_rd_addr];
    if (!bus.ram_wr_en) mem[bus.ram_wr_addr] <= bus.ram_wr_data;
  end

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  bit   mon_en = 0;

  logic [DW-1:0] prev [64];
  logic [DW-1:0] cur  [64];
  int   c          = 0;
  bit   prev_valid = 0;
  int   drain_left = 0;
  int   mode_m     = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Address of index j after rotating its base-4 digits right m times.
  function automatic int exp_addr(input int j, input int m);
    int d0, d1, d2;
    d0 = j % 4;
    d1 = (j / 4) % 4;
    d2 = j / 16;
    case (m)
      1:       return d0 * 16 + d2 * 4 + d1;
      2:       return d1 * 16 + d0 * 4 + d2;
      default: return j;
    endcase
  endfunction

  // Output position i of a frame carries sample x[i/4 + 16*(i%4)].
  function automatic int bfly_idx(input int i);
    return (i % 4) * 16 + i / 4;
  endfunction

  task automatic model_reset();
    c          = 0;
    prev_valid = 0;
    drain_left = 0;
    mode_m     = 0;
    q.delete();
  endtask

  task automatic cyc(input bit v, input logic [DW-1:0] d, input bit f);
    bit exp_ready, acc;
    @(negedge clk_sys);
    bus.in_valid = v;
    bus.in_data  = d;
    bus.flush    = f;
    #1;
    exp_ready = (drain_left == 0);
    acc       = v && exp_ready;
    check("in_ready", 64'(bus.in_ready), 64'(exp_ready));
    check("ram_wr_en", 64'(bus.ram_wr_en), 64'(!acc));
    if (acc) begin
      check("ram_wr_addr", 64'(bus.ram_wr_addr), 64'(exp_addr(c, mode_m)));
      check("ram_rd_addr", 64'(bus.ram_rd_addr), 64'(exp_addr(c, mode_m)));
      check("ram_wr_data", 64'(bus.ram_wr_data), 64'(d));
      if (prev_valid) q.push_back('{d: prev[bfly_idx(c)], sop: (c == 0), eop: (c == 63)});
      cur[c] = d;
      c++;
      if (c == 64) begin
        c          = 0;
        prev       = cur;
        prev_valid = 1;
        mode_m     = (mode_m + 1) % 3;
      end
    end else if (drain_left > 0) begin
      drain_left--;
      if (drain_left == 0) mode_m = 0;
    end else if (f && c == 0 && prev_valid) begin
      for (int i = 0; i < 64; i++)
        q.push_back('{d: prev[bfly_idx(i)], sop: (i == 0), eop: (i == 63)});
      prev_valid = 0;
      drain_left = 64;
    end
  endtask

  task automatic do_reset();
    @(negedge clk_sys);
    rst_sys_n    = 1'b0;
    bus.in_valid = 1'b0;
    bus.flush    = 1'b0;
    bus.in_data  = '0;
    model_reset();
    @(negedge clk_sys);
    rst_sys_n = 1'b1;
    #1;
    check("rst_out_valid", 64'(bus.out_valid), 64'(0));
    check("rst_out_sop", 64'(bus.out_sop), 64'(0));
    check("rst_out_eop", 64'(bus.out_eop), 64'(0));
    check("rst_in_ready", 64'(bus.in_ready), 64'(1));
    check("rst_wr_en", 64'(bus.ram_wr_en), 64'(1));
    check("rst_rd_addr", 64'(bus.ram_rd_addr), 64'(0));
    check("rst_wr_addr", 64'(bus.ram_wr_addr), 64'(0));
  endtask

  function automatic logic [DW-1:0] rnd_data();
    logic [63:0] t;
    t = {$urandom(), $urandom()};
    return t[DW-1:0];
  endfunction

  // Issue n accepted beats; data is base+k or random, with optional ~50% gaps.
  task automatic send(input int n, input int base, input bit rnd, input bit gaps);
    int k = 0;
    int guard = 0;
    while (k < n && guard < 4000) begin
      bit v;
      logic [DW-1:0] d;
      v = gaps ? bit'($urandom_range(0, 1)) : 1'b1;
      d = rnd ? rnd_data() : DW'(base + k);
      cyc(v, d, 1'b0);
      if (v && drain_left == 0) k++;
      guard++;
    end
    if (k < n) begin
      errors++;
      $display("FAIL send_timeout: got %0d beats expected %0d", k, n);
    end
  endtask

  initial begin : monitor
    exp_t e;
    wait (mon_en);
    forever begin
      @(posedge clk_sys);
      #1;
      if (bus.out_valid === 1'b1) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL out_valid_unexpected: got out_valid=1 data=%0h expected no output", bus.out_data);
        end else begin
          e = q.pop_front();
          check("out_data", 64'(bus.out_data), 64'(e.d));
          check("out_sop", 64'(bus.out_sop), 64'(e.sop));
          check("out_eop", 64'(bus.out_eop), 64'(e.eop));
        end
      end
    end
  end

  initial begin : stimulus
    int low_cnt;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    bus.flush    = 1'b0;
    repeat (3) @(negedge clk_sys);
    do_reset();
    mon_en = 1;

    send(64, 0, 0, 0);
    send(64, 100, 0, 0);

    // Drain the 100+j frame; count cycles with input blocked.
    cyc(1'b0, '0, 1'b1);
    low_cnt = 0;
    for (int i = 0; i < 70; i++) begin
      cyc(1'b0, '0, 1'b0);
      if (!bus.in_ready) low_cnt++;
    end
    check("drain_ready_low_cycles", 64'(low_cnt), 64'(64));

    cyc(1'b0, '0, 1'b1);
    repeat (3) cyc(1'b0, '0, 1'b0);
    send(64, 0, 1, 0);
    send(20, 0, 1, 0);
    cyc(1'b0, '0, 1'b1);
    send(44, 0, 1, 0);
    cyc(1'b1, rnd_data(), 1'b1);
    send(63, 0, 1, 1);
    for (int fr = 0; fr < 4; fr++) send(64, 0, 1, 1);

    send(30, 0, 1, 0);
    do_reset();
    send(64, 0, 1, 0);
    send(64, 0, 1, 1);
    cyc(1'b0, '0, 1'b1);
    repeat (70) cyc(1'b0, '0, 1'b0);

    repeat (5) cyc(1'b0, '0, 1'b0);
    check("scoreboard_empty", 64'(q.size()), 64'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
